serdes_lane_stream_cipher: RTL and testbench

//  Multi-lane serial stream encryptor. Deserialises one WIDTH-bit frame per lane and XORs it with an LFSR keystream.

---
 rtl/serdes_cipher_pkg.sv | 44 ++++
 rtl/serdes_keystream_lfsr.sv | 29 ++
 rtl/serdes_lane_stream_cipher.sv | 139 +++++++++++++
 tb/tb_serdes_lane_stream_cipher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_cipher_pkg.sv
// Shared types and helpers for the multi-lane serial stream cipher.
// Holds the FSM state enum, default Galois taps, LFSR step and keystream rotate.
package serdes_cipher_pkg;

  // Helpers work on a fixed wide vector; callers zero-extend and truncate.
  localparam int KW_MAX = 64;
  localparam int KW_IW  = $clog2(KW_MAX);

  localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_ENCRYPT,
    S_EMIT,
    S_DONE
  } state_t;

  // One Galois step. Upper bits of s must be zero beyond the key width.
  function automatic logic [KW_MAX-1:0] lfsr_step(
    input logic [KW_MAX-1:0] s,
    input logic [KW_MAX-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

  // Low `width` bits of s rotated left by `lane` within kw bits.
  function automatic logic [KW_MAX-1:0] rotl_ks(
    input logic [KW_MAX-1:0] s,
    input int                lane,
    input int                width,
    input int                kw
  );
    logic [KW_MAX-1:0] r;
    logic [KW_IW-1:0]  idx;
    r = '0;
    for (int i = 0; i < KW_MAX; i++) begin
      idx = KW_IW'((i + kw - lane) % kw);
      if (i < width) r[i] = s[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/serdes_keystream_lfsr.sv
// Keystream LFSR: key load (zero key forced to 1) and one Galois step on advance.
// Ports: clk, rst_n, load, key[KEY_W], advance -> lfsr_q[KEY_W].
module serdes_keystream_lfsr
  import serdes_cipher_pkg::*;
#(
  parameter int               KEY_W     = 16,
  parameter logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(LFSR_TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key,
  input  logic             advance,
  output logic [KEY_W-1:0] lfsr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= KEY_W'(1);
    end else if (load) begin
      // An all-zero Galois LFSR never leaves zero.
      lfsr_q <= (key == '0) ? KEY_W'(1) : key;
    end else if (advance) begin
      lfsr_q <= KEY_W'(lfsr_step(KW_MAX'(lfsr_q),
                                 KW_MAX'(LFSR_TAPS)));
    end
  end

endmodule

// File: rtl/serdes_lane_stream_cipher.sv
// Multi-lane serial stream encryptor: capture, XOR with LFSR keystream, emit MSB first.
// Ports: clk, rst_n, start, key_load, key, din, din_valid -> dout, dout_valid, busy, done.
// Option: define SERDES_PARITY_EN to append an even-parity bit per lane after the data.
module serdes_lane_stream_cipher
  import serdes_cipher_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 2,
  parameter int               KEY_W     = 16,
  parameter logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(LFSR_TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key,
  input  logic [LANES-1:0] din,
  input  logic             din_valid,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

`ifdef SERDES_PARITY_EN
  localparam int EMIT_LEN = WIDTH + 1;
`else
  localparam int EMIT_LEN = WIDTH;
`endif
  localparam int CW = $clog2(EMIT_LEN + 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg [LANES];
  logic [WIDTH-1:0] ks    [LANES];
  logic [KEY_W-1:0] lfsr_q;
`ifdef SERDES_PARITY_EN
  logic [LANES-1:0] par;
`endif

  serdes_keystream_lfsr #(
    .KEY_W     (KEY_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == S_IDLE && key_load),
    .key     (key),
    .advance (state == S_ENCRYPT),
    .lfsr_q  (lfsr_q)
  );

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      ks[l] = WIDTH'(rotl_ks(KW_MAX'(lfsr_q), l, WIDTH, KEY_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = S_CAPTURE;
      S_CAPTURE:
        if (din_valid && cnt == CW'(WIDTH - 1))
          state_n = S_ENCRYPT;
      S_ENCRYPT:
        state_n = S_EMIT;
      S_EMIT:
        if (cnt == CW'(EMIT_LEN - 1))
          state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // cnt counts captured bits, then is reused to count emitted bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int l = 0; l < LANES; l++) shreg[l] <= '0;
`ifdef SERDES_PARITY_EN
      par <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE:
          if (start) cnt <= '0;
        S_CAPTURE:
          if (din_valid) begin
            cnt <= cnt + 1'b1;
            for (int l = 0; l < LANES; l++)
              shreg[l] <= {shreg[l][WIDTH-2:0], din[l]};
          end
        S_ENCRYPT: begin
          cnt <= '0;
          for (int l = 0; l < LANES; l++) begin
            shreg[l] <= shreg[l] ^ ks[l];
`ifdef SERDES_PARITY_EN
            par[l] <= ^(shreg[l] ^ ks[l]);
`endif
          end
        end
        S_EMIT: begin
          cnt <= cnt + 1'b1;
          for (int l = 0; l < LANES; l++)
            shreg[l] <= shreg[l] << 1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = (state == S_EMIT);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    if (state == S_EMIT) begin
      for (int l = 0; l < LANES; l++) begin
`ifdef SERDES_PARITY_EN
        dout[l] = (cnt == CW'(WIDTH)) ? par[l]
                                      : shreg[l][WIDTH-1];
`else
        dout[l] = shreg[l][WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_serdes_lane_stream_cipher.sv
// Self-checking bench for serdes_lane_stream_cipher (WIDTH=8, LANES=2, KEY_W=16).
// Honours SERDES_PARITY_EN when the design is built with it.
module tb_serdes_lane_stream_cipher;

  localparam logic [15:0] TAPS = 16'hB400;
`ifdef SERDES_PARITY_EN
  localparam int EXP_VALID = 9;
`else
  localparam int EXP_VALID = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        key_load;
  logic [15:0] key;
  logic [1:0]  din;
  logic        din_valid;
  logic [1:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic        done;

  serdes_lane_stream_cipher #(
    .WIDTH     (8),
    .LANES     (2),
    .KEY_W     (16),
    .LFSR_TAPS (TAPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_load   (key_load),
    .key        (key),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] mlfsr;
  logic [8:0]  col0, col1;
  logic [7:0]  ct0, ct1;
  int          first_lat, last_vc, done_c;
  int          nvalid, ndone;
  logic [7:0]  rp0, rp1;

  // Keystream: low 8 bits of the state rotated left by the lane index.
  function automatic logic [7:0] ks(input logic [15:0] s, input int l);
    logic [15:0] r;
    r = (l == 0) ? s : ((s << l) | (s >> (16 - l)));
    return r[7:0];
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [15:0] k);
    key = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    mlfsr = (k == 16'h0) ? 16'h1 : k;
  endtask

  // Runs one frame from the start pulse; collects emitted bits and timing.
  task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1,
                           input int stall_at, input int stall_len,
                           input logic poke);
    int sent;
    int stalled;
    sent = 0;
    stalled = 0;
    col0 = '0;
    col1 = '0;
    nvalid = 0;
    ndone = 0;
    first_lat = -1;
    last_vc = -1;
    done_c = -1;
    start = 1'b1;
    din_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (dout_valid) begin
        if (nvalid == 0) first_lat = c;
        col0 = {col0[7:0], dout[0]};
        col1 = {col1[7:0], dout[1]};
        nvalid++;
        last_vc = c;
      end
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      start = 1'b0;
      key_load = 1'b0;
      if (poke && nvalid == 3) begin
        start = 1'b1;
        key_load = 1'b1;
        key = 16'($urandom);
      end
      if (poke && nvalid == EXP_VALID && done_c < 0)
        start = 1'b1;
      if (sent == stall_at && stalled < stall_len) begin
        din_valid = 1'b0;
        din = 2'($urandom);
        stalled++;
      end else if (sent < 8) begin
        din_valid = 1'b1;
        din = {p1[7-sent], p0[7-sent]};
        sent++;
      end else begin
        din_valid = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    key_load = 1'b0;
    din_valid = 1'b0;
`ifdef SERDES_PARITY_EN
    ct0 = col0[8:1];
    ct1 = col1[8:1];
`else
    ct0 = col0[7:0];
    ct1 = col1[7:0];
`endif
  endtask

  task automatic check_frame(input string tag, input logic [7:0] p0,
                             input logic [7:0] p1, input int stall_len);
    logic [7:0] e0, e1;
    e0 = p0 ^ ks(mlfsr, 0);
    e1 = p1 ^ ks(mlfsr, 1);
    chk({tag, "_done_seen"}, 32'(done_c >= 0), 1);
    chk({tag, "_lane0"}, ct0, e0);
    chk({tag, "_lane1"}, ct1, e1);
`ifdef SERDES_PARITY_EN
    chk({tag, "_par0"}, col0[0], ^e0);
    chk({tag, "_par1"}, col1[0], ^e1);
`endif
    chk({tag, "_latency"}, first_lat, 10 + stall_len);
    chk({tag, "_nvalid"}, nvalid, EXP_VALID);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_done_pos"}, done_c, last_vc + 1);
    chk({tag, "_idle_after"}, busy, 0);
    mlfsr = adv(mlfsr);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_load = 1'b0;
    key = '0;
    din = '0;
    din_valid = 1'b0;
    mlfsr = 16'h1;
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed frame with known key.
    load_key(16'h00A5);
    run_frame(8'h3C, 8'hFF, -1, 0, 1'b0);
    chk("t1_lit0", ct0, 8'h99);
    chk("t1_lit1", ct1, 8'hB5);
`ifdef SERDES_PARITY_EN
    chk("t1_litpar0", col0[0], 0);
    chk("t1_litpar1", col1[0], 1);
`endif
    check_frame("t1", 8'h3C, 8'hFF, 0);

    // Keystream continues without reload.
    run_frame(8'h00, 8'h00, -1, 0, 1'b0);
    chk("t2_lit0", ct0, 8'h52);
    check_frame("t2", 8'h00, 8'h00, 0);

    // Input stall in the middle of capture.
    load_key(16'h00A5);
    run_frame(8'h3C, 8'hFF, 4, 3, 1'b0);
    chk("t3_lit0", ct0, 8'h99);
    check_frame("t3", 8'h3C, 8'hFF, 3);

    // Zero key, plus start/key_load poked while busy and in DONE.
    load_key(16'h0000);
    rp1 = 8'($urandom);
    run_frame(8'h00, rp1, -1, 0, 1'b1);
    chk("t4_lit0", ct0, 8'h01);
    check_frame("t4", 8'h00, rp1, 0);
    rp0 = 8'($urandom);
    rp1 = 8'($urandom);
    run_frame(rp0, rp1, -1, 0, 1'b0);
    check_frame("t4_next", rp0, rp1, 0);

    // Reset in the middle of capture.
    load_key(16'($urandom) | 16'h8000);
    start = 1'b1;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 2'($urandom);
      tick();
    end
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_dout_valid", dout_valid, 0);
    chk("t5_dout", dout, 0);
    chk("t5_done", done, 0);
    tick();
    chk("t5_done_hold", done, 0);
    rst_n = 1'b1;
    mlfsr = 16'h1;
    tick();
    rp0 = 8'($urandom);
    rp1 = 8'($urandom);
    run_frame(rp0, rp1, -1, 0, 1'b0);
    check_frame("t5_after", rp0, rp1, 0);

    // Randomized frames with occasional key reloads and stalls.
    for (int n = 0; n < 6; n++) begin
      int sa, sl;
      if ($urandom_range(0, 1) == 1) load_key(16'($urandom));
      rp0 = 8'($urandom);
      rp1 = 8'($urandom);
      sa = $urandom_range(0, 7);
      sl = $urandom_range(0, 4);
      run_frame(rp0, rp1, sa, sl, 1'b0);
      check_frame("rand", rp0, rp1, sl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
